// File: rtl/fir_out_stage.sv
// Output stage behind the 4-tap FIR sum register: warm-up discard, divide-by-4 average,
// small FIFO with valid/ready, overflow accounting. Build macro FIR_OUT_ROUND_EN selects round-half-up.
module fir_out_stage #(
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 4,
    parameter int CNTW   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W+1:0]             din,
    input  logic                     din_valid,
    output logic [W-1:0]             dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNTW-1:0]          drop_cnt,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [WCW-1:0]  warm_q, warm_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
    logic            overflow_q, overflow_d;

    logic [W-1:0]    mem [DEPTH];
    logic [W-1:0]    avg;
    logic            warm_done;
    logic            accepted;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;
    logic [PW-1:0]   count;

`ifdef FIR_OUT_ROUND_EN
    logic [W+2:0] sum_ext;
    logic         unused_avg_bits;

    assign sum_ext         = {1'b0, din} + (W+3)'(2);
    assign avg             = sum_ext[W+1:2];
    assign unused_avg_bits = ^{sum_ext[W+2], sum_ext[1:0]};
`else
    logic unused_avg_bits;

    assign avg             = din[W+1:2];
    assign unused_avg_bits = ^din[1:0];
`endif

    assign warm_done  = (warm_q == WCW'(WARMUP));
    assign accepted   = din_valid && warm_done;
    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == PW'(DEPTH));
    assign pop        = dout_valid && dout_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign wr_en      = accepted && (!full || pop);
    assign drop       = accepted && full && !pop;

    assign dout_valid = (count != '0);
    assign fifo_count = count;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;
    assign dout       = dout_valid ? mem[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        warm_d     = warm_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (din_valid && !warm_done) begin
            warm_d = warm_q + WCW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (reset) begin
            warm_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            warm_q     <= warm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; dout is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= avg;
        end
    end

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage with a queue-based reference model checked every cycle.
module tb_fir_out_stage;

    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 4;
    localparam int CNTW   = 8;

    logic          clk;
    logic          reset;
    logic [W+1:0]  din;
    logic          din_valid;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [2:0]    fifo_count;
    logic [7:0]    drop_cnt;
    logic          overflow;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int m_q[$];
    int m_warm = 0;
    int m_drop = 0;
    bit m_ovf  = 0;
    bit m_pop;
    bit m_acc;

    fir_out_stage #(.W(W), .DEPTH(DEPTH), .WARMUP(WARMUP), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int avg_of(int d);
`ifdef FIR_OUT_ROUND_EN
        return (d + 2) / 4;
`else
        return d / 4;
`endif
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int d);
        din_valid = v;
        din       = (W+2)'(d);
        cyc();
    endtask

    // Model: warm-up count, then a bounded queue with drop accounting.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_warm = 0;
                m_drop = 0;
                m_ovf  = 0;
            end else begin
                m_pop = (m_q.size() != 0) && dout_ready;
                m_acc = din_valid && (m_warm == WARMUP);
                if (din_valid && m_warm < WARMUP) m_warm++;
                if (m_pop) void'(m_q.pop_front());
                if (m_acc) begin
                    if (m_q.size() >= DEPTH) begin
                        m_ovf = 1;
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_q.push_back(avg_of(int'(din)));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_valid", dout_valid, (m_q.size() != 0));
            check("cmp_count", fifo_count, m_q.size());
            check("cmp_drop", drop_cnt, m_drop);
            check("cmp_ovf", overflow, m_ovf);
            if (m_q.size() != 0) check("cmp_dout", dout, m_q[0]);
        end
    end

    initial begin
        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_count", fifo_count, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        cyc();

        // 1: warm-up discards four samples, fifth emerges after its edge
        for (int i = 0; i < 4; i++) begin
            drive(1, 1000 + i * 7);
            check("t1_warm_valid", dout_valid, 0);
        end
        drive(1, 100);
        check("t1_valid", dout_valid, 1);
        check("t1_dout", dout, 25);
        check("t1_count", fifo_count, 1);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        cyc();
        check("t1_drained", dout_valid, 0);

        // 2: scaling with continuous ready
        drive(1, 6);
`ifdef FIR_OUT_ROUND_EN
        check("t2_dout_a", dout, 2);
`else
        check("t2_dout_a", dout, 1);
`endif
        drive(1, 10);
`ifdef FIR_OUT_ROUND_EN
        check("t2_dout_b", dout, 3);
`else
        check("t2_dout_b", dout, 2);
`endif
        drive(1, 262140);
        check("t2_dout_max", dout, 65535);
        drive(0, 0);
        check("t2_empty", dout_valid, 0);

        // 3: overflow while stalled, then ordered drain
        dout_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive(1, 4 * i);
        check("t3_count", fifo_count, 4);
        check("t3_drop", drop_cnt, 2);
        check("t3_ovf", overflow, 1);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", dout, i);
            cyc();
        end
        check("t3_empty", dout_valid, 0);

        // 4: full FIFO with simultaneous push and pop
        dout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(1, 40 * i);
        check("t4_full", fifo_count, 4);
        dout_ready = 1'b1;
        drive(1, 200);
        check("t4_count", fifo_count, 4);
        check("t4_drop", drop_cnt, 2);
        din_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            check("t4_order", dout, 10 * i);
            cyc();
        end
        check("t4_empty", dout_valid, 0);

        // 5: asynchronous reset mid-stream
        dout_ready = 1'b0;
        for (int i = 1; i <= 3; i++) drive(1, 4 * i);
        din_valid = 1'b0;
        check("t5_count3", fifo_count, 3);
        #3;
        reset = 1'b1;
        #1;
        check("t5_async_valid", dout_valid, 0);
        check("t5_async_count", fifo_count, 0);
        check("t5_async_drop", drop_cnt, 0);
        check("t5_async_ovf", overflow, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 500);
            check("t5_warm_valid", dout_valid, 0);
        end
        drive(1, 400);
        check("t5_dout", dout, 100);
        drive(0, 0);

        // 6: drop counter saturation
        dout_ready = 1'b0;
        for (int i = 0; i < 4 + 254; i++) drive(1, 8);
        check("t6_drop254", drop_cnt, 254);
        drive(1, 8);
        check("t6_drop255", drop_cnt, 255);
        for (int i = 0; i < 45; i++) drive(1, 8);
        check("t6_sat", drop_cnt, 255);
        check("t6_ovf", overflow, 1);
        check("t6_count", fifo_count, 4);
        drive(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
